// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, constants and width helpers for the instruction cache
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } icache_state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_bytes, input int num_lines);
        return addr_w - off_w(line_bytes) - idx_w(num_lines);
    endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - REQ/FILL refill FSM, beat counter, latched line address, poison flag
//   in : clk_i, rst_ni, start_i (miss in IDLE), start_addr_i, flush_i,
//        mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i
//   out: idle_o, mem_req_valid_o, mem_req_addr_o, data_we_o, wr_idx_o, wr_word_o,
//        wr_data_o, tag_we_o, tag_o, valid_set_o
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int LINE_BYTES = 16,
    parameter int NUM_LINES  = 64,
    parameter int OFF_W      = off_w(LINE_BYTES),
    parameter int IDX_W      = idx_w(NUM_LINES),
    parameter int TAG_W      = tag_w(ADDR_W, LINE_BYTES, NUM_LINES),
    parameter int WORD_W     = (OFF_W > 2) ? OFF_W - 2 : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic              flush_i,
    input  logic              mem_req_ready_i,
    input  logic              mem_resp_valid_i,
    input  logic [31:0]       mem_resp_data_i,
    output logic              idle_o,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic              data_we_o,
    output logic [IDX_W-1:0]  wr_idx_o,
    output logic [WORD_W-1:0] wr_word_o,
    output logic [31:0]       wr_data_o,
    output logic              tag_we_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              valid_set_o
);

    localparam int LINE_WORDS = LINE_BYTES / 4;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    icache_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;
    logic              poison_q, poison_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            poison_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            poison_q <= poison_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        poison_d    = poison_q;
        data_we_o   = 1'b0;
        tag_we_o    = 1'b0;
        valid_set_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d            = start_addr_i;
                    addr_d[OFF_W-1:0] = '0;
                    state_d           = REQ;
                end
            end
            REQ: begin
                if (flush_i) poison_d = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                if (flush_i) poison_d = 1'b1;
                if (mem_resp_valid_i) begin
                    data_we_o = 1'b1;
                    cnt_d     = cnt_q + WORD_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        // A flush landing on the final beat must also keep the line invalid.
                        tag_we_o    = 1'b1;
                        valid_set_o = !poison_q && !flush_i;
                        poison_d    = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idle_o          = (state_q == IDLE);
    assign mem_req_valid_o = (state_q == REQ);
    assign mem_req_addr_o  = addr_q;
    assign wr_idx_o        = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign tag_o           = addr_q[ADDR_W-1:OFF_W+IDX_W];
    assign wr_word_o       = cnt_q;
    assign wr_data_o       = mem_resp_data_i;

endmodule

// File: rtl/instruction_cache_dm.sv
// rtl/instruction_cache_dm.sv - direct-mapped instruction cache: valid/tag/data arrays, hit path, stats
//   Fetch side: CLK, RESET_N, PC, fetch_valid, flush -> instruction, instr_valid
//   Memory side: mem_req_valid/mem_req_addr/mem_req_ready, mem_resp_valid/mem_resp_data
//   Optional (ICACHE_STATS_EN): hit_count, miss_count
module instruction_cache_dm
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int LINE_BYTES = 16,
    parameter int NUM_LINES  = 64
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] PC,
    input  logic              fetch_valid,
    input  logic              flush,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int LINE_WORDS = LINE_BYTES / 4;
    localparam int OFF_W      = off_w(LINE_BYTES);
    localparam int IDX_W      = idx_w(NUM_LINES);
    localparam int TAG_W      = tag_w(ADDR_W, LINE_BYTES, NUM_LINES);
    localparam int WORD_W     = (OFF_W > 2) ? OFF_W - 2 : 1;
    localparam int ENT_W      = IDX_W + WORD_W;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [1 << ENT_W];

    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [WORD_W-1:0] pc_word;
    logic              unused_pc;
    logic              idle, lookup, tag_hit, hit, miss_start;
    logic              data_we, tag_we, valid_set;
    logic [IDX_W-1:0]  wr_idx;
    logic [WORD_W-1:0] wr_word;
    logic [31:0]       wr_data;
    logic [TAG_W-1:0]  wr_tag;

    assign pc_idx    = PC[OFF_W+IDX_W-1:OFF_W];
    assign pc_tag    = PC[ADDR_W-1:OFF_W+IDX_W];
    // With one-word lines the word field is empty; masking forces it to zero.
    assign pc_word   = WORD_W'(PC[ADDR_W-1:2]) & WORD_W'(LINE_WORDS - 1);
    assign unused_pc = ^PC[1:0];

    assign lookup     = idle && fetch_valid && !flush;
    assign tag_hit    = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign hit        = lookup && tag_hit;
    assign miss_start = lookup && !tag_hit;

    assign instr_valid = hit;
    assign instruction = hit ? data_q[{pc_idx, pc_word}] : NOP;

    icache_refill_ctrl #(
        .ADDR_W    (ADDR_W),
        .LINE_BYTES(LINE_BYTES),
        .NUM_LINES (NUM_LINES)
    ) u_refill (
        .clk_i           (CLK),
        .rst_ni          (RESET_N),
        .start_i         (miss_start),
        .start_addr_i    (PC),
        .flush_i         (flush),
        .mem_req_ready_i (mem_req_ready),
        .mem_resp_valid_i(mem_resp_valid),
        .mem_resp_data_i (mem_resp_data),
        .idle_o          (idle),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_addr_o  (mem_req_addr),
        .data_we_o       (data_we),
        .wr_idx_o        (wr_idx),
        .wr_word_o       (wr_word),
        .wr_data_o       (wr_data),
        .tag_we_o        (tag_we),
        .tag_o           (wr_tag),
        .valid_set_o     (valid_set)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (valid_set) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid_q alone qualifies them.
    always_ff @(posedge CLK) begin
        if (data_we) data_q[{wr_idx, wr_word}] <= wr_data;
        if (tag_we)  tag_q[wr_idx] <= wr_tag;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit)        hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache_dm.sv
// tb/tb_instruction_cache_dm.sv - directed self-checking bench for instruction_cache_dm
module tb_instruction_cache_dm;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [63:0] PC;
    logic        fetch_valid, flush;
    logic [31:0] instruction;
    logic        instr_valid, mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready, mem_resp_valid;
    logic [31:0] mem_resp_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    instruction_cache_dm dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .PC            (PC),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Entered one step after an edge with the FSM in FILL; returns likewise with it back in IDLE.
    task automatic fill(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3, input int gap);
        logic [31:0] w [4];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            repeat (gap) begin
                mem_resp_valid = 1'b0;
                tick();
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = w[i];
            tick();
        end
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; PC = '0; fetch_valid = 1'b0; flush = 1'b0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
        tick(); tick();
        chk("rst_ivalid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, instruction}, 64'h13);
        chk("rst_reqv", {63'd0, mem_req_valid}, 64'd0);
        RESET_N = 1'b1;
        tick();

        // Cold miss at PC 0, full 6-cycle refill then zero-latency hits.
        fetch_valid = 1'b1; PC = 64'h0;
        #1;
        chk("miss0_ivalid", {63'd0, instr_valid}, 64'd0);
        chk("miss0_instr", {32'd0, instruction}, 64'h13);
        tick();
        chk("req0_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("req0_addr", mem_req_addr, 64'h0);
        chk("req0_ivalid", {63'd0, instr_valid}, 64'd0);
        tick();
        fill(32'h0050_0093, 32'h0020_8113, 32'h0, 32'h0, 0);
        chk("hit0_ivalid", {63'd0, instr_valid}, 64'd1);
        chk("hit0_instr", {32'd0, instruction}, 64'h0050_0093);
        PC = 64'h4; #1;
        chk("hit4_instr", {32'd0, instruction}, 64'h0020_8113);
        PC = 64'h8; #1;
        chk("hit8_instr", {32'd0, instruction}, 64'h0);

        // Conflict: 0x400 maps onto index 0 with a different tag.
        PC = 64'h400; #1;
        chk("conf_ivalid", {63'd0, instr_valid}, 64'd0);
        tick();
        chk("conf_addr", mem_req_addr, 64'h400);
        tick();
        fill(32'h11, 32'h22, 32'h33, 32'h44, 0);
        chk("conf_hit", {32'd0, instruction}, 64'h11);
        PC = 64'h40C; #1;
        chk("conf_w3", {32'd0, instruction}, 64'h44);

        // PC 0 was evicted; refill it under request backpressure and beat gaps.
        PC = 64'h0; mem_req_ready = 1'b0; #1;
        chk("evict_ivalid", {63'd0, instr_valid}, 64'd0);
        tick();
        PC = 64'h800;
        for (int i = 0; i < 5; i++) begin
            chk("bp_reqv", {63'd0, mem_req_valid}, 64'd1);
            chk("bp_addr", mem_req_addr, 64'h0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        fill(32'hA0, 32'hA1, 32'hA2, 32'hA3, 2);
        PC = 64'h0; #1;
        chk("gap_w0", {32'd0, instruction}, 64'hA0);
        PC = 64'h8; #1;
        chk("gap_w2", {32'd0, instruction}, 64'hA2);
        PC = 64'hC; #1;
        chk("gap_w3", {32'd0, instruction}, 64'hA3);

        // Flush on beat 2 poisons the refill of PC 0x20.
        PC = 64'h20; #1;
        tick();
        chk("fl_addr", mem_req_addr, 64'h20);
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hB0 + i;
            flush          = (i == 2);
            tick();
        end
        mem_resp_valid = 1'b0; flush = 1'b0; #1;
        chk("poison_miss", {63'd0, instr_valid}, 64'd0);
        tick();
        chk("poison_req", {63'd0, mem_req_valid}, 64'd1);
        tick();
        fill(32'hC0, 32'hC1, 32'hC2, 32'hC3, 0);
        chk("refill_hit", {32'd0, instruction}, 64'hC0);

        // Flush in IDLE kills the current cycle and the line.
        flush = 1'b1; #1;
        chk("flidle_ivalid", {63'd0, instr_valid}, 64'd0);
        tick();
        flush = 1'b0; #1;
        chk("after_fl_miss", {63'd0, instr_valid}, 64'd0);
        tick();
        chk("after_fl_req", {63'd0, mem_req_valid}, 64'd1);
        tick();

        // Reset in the middle of FILL, then stray beats after release.
        mem_resp_valid = 1'b1; mem_resp_data = 32'hD0;
        tick();
        RESET_N = 1'b0; mem_resp_valid = 1'b0; #1;
        chk("rstmid_reqv", {63'd0, mem_req_valid}, 64'd0);
        chk("rstmid_ivalid", {63'd0, instr_valid}, 64'd0);
        tick();
        RESET_N = 1'b1; fetch_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        tick(); tick();
        chk("stray_reqv", {63'd0, mem_req_valid}, 64'd0);
        mem_resp_valid = 1'b0;

        // Two misses, then ten hit cycles.
        fetch_valid = 1'b1; PC = 64'h0; #1;
        chk("post_rst_miss", {63'd0, instr_valid}, 64'd0);
        tick();
        chk("post_rst_req", mem_req_addr, 64'h0);
        tick();
        fill(32'hE0, 32'hE1, 32'hE2, 32'hE3, 0);
        fetch_valid = 1'b0;
        chk("post_rst_data", {32'd0, dut.data_q[0]}, 64'hE0);
        fetch_valid = 1'b1; PC = 64'h40;
        tick();
        tick();
        fill(32'hF0, 32'hF1, 32'hF2, 32'hF3, 0);
        fetch_valid = 1'b0;
        PC = 64'h44;
        fetch_valid = 1'b1;
        repeat (10) tick();
        chk("stats_last_hit", {32'd0, instruction}, 64'hF1);
        fetch_valid = 1'b0; #1;
`ifdef ICACHE_STATS_EN
        chk("miss_count", {32'd0, miss_count}, 64'd2);
        chk("hit_count", {32'd0, hit_count}, 64'd10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_cache_dm.md
# instruction_cache_dm

Direct-mapped, parametrised instruction cache between the fetch stage and the memory bus. It replaces the flat preloaded instruction memory with tagged lines that are refilled over a valid/ready memory interface. Hits return an instruction combinationally in the same cycle. Misses stall fetch, via `instr_valid` low, until a line refill completes.

## Interface
- `ADDR_W`, 64: PC / memory address width.
- `LINE_BYTES`, 16: bytes per line; a power of two, at least 4.
- `NUM_LINES`, 64: number of lines; a power of two, at least 2.
- `CLK` input 1: clock; all state changes on the rising edge.
- `RESET_N` input 1: reset, asynchronous, active-low.
- `PC` input `ADDR_W`: fetch address; `PC[1:0]` ignored.
- `fetch_valid` input 1: fetch stage requests the instruction at `PC`.
- `flush` input 1: invalidate all lines (fence.i).
- `instruction` output 32: instruction word; reads 32'h0000_0013 (NOP) whenever `instr_valid` is 0.
- `instr_valid` output 1: `instruction` is valid for the current `PC`.
- `mem_req_valid` output 1: line refill request.
- `mem_req_addr` output `ADDR_W`: line-aligned refill address.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_resp_valid` input 1: one response beat.
- `mem_resp_data` input 32: beat data; beats arrive in word order 0..`LINE_WORDS`-1.
- `hit_count` output 32: present only with `ICACHE_STATS_EN`.
- `miss_count` output 32: present only with `ICACHE_STATS_EN`.

## Operation
- Derived widths:
  - `LINE_WORDS` = `LINE_BYTES`/4.
  - `OFF_W` = log2(`LINE_BYTES`).
  - `IDX_W` = log2(`NUM_LINES`).
  - `TAG_W` = `ADDR_W`−`OFF_W`−`IDX_W`.
- Address fields:
  - index = `PC[OFF_W+IDX_W-1:OFF_W]`.
  - word = `PC[OFF_W-1:2]`.
  - tag = `PC[ADDR_W-1:OFF_W+IDX_W]`.
- Hit condition: state IDLE, `fetch_valid`, valid[index], tag match, and `flush` low. On a hit `instr_valid`=1 and `instruction`=data[index][word], both combinational.
- States:
  - IDLE: serves lookups. On `fetch_valid` with a miss and no `flush`, latch the line-aligned address (PC with low `OFF_W` bits cleared) and go to REQ.
  - REQ: `mem_req_valid`=1 and `mem_req_addr` holds the latched value. Both stay stable until `mem_req_ready` is sampled 1, then go to FILL with beat counter = 0.
  - FILL: each `mem_resp_valid` writes `mem_resp_data` into data[latched index][beat counter] and increments the counter. On the final beat, write the tag, set valid (unless poisoned), and return to IDLE.
- Beats are accepted only in FILL; `mem_resp_valid` in any other state is ignored.
- `PC` changes during REQ/FILL do not affect the refill in flight. `instr_valid` is 0 in REQ and FILL.
- Flush:
  - In IDLE: clears all valid bits at the edge, and `instr_valid` is 0 that cycle.
  - In REQ/FILL: clears all valid bits and sets a poison flag. The refill completes normally but does not set valid; poison clears on return to IDLE.
- Valid bits: reset to 0. Tag and data arrays are not reset.

## Timing
- Hit: 0-cycle latency, combinational from `PC`.
- Miss, with immediate ready and back-to-back beats:
  - cycle 0: miss detected;
  - cycle 1: REQ handshake;
  - cycles 2..`LINE_WORDS`+1: beats;
  - cycle `LINE_WORDS`+2: hit in IDLE.
  - Total `LINE_WORDS`+2 cycles; 6 for defaults.
- Reset values: state IDLE, `mem_req_valid`=0, `instr_valid`=0, `instruction`=NOP, counters 0, poison 0.
- `RESET_N` asserted mid-refill aborts immediately; outstanding memory beats after release are ignored (state IDLE).
- `mem_req_valid` never drops without the handshake completing, except on reset.

## Configuration
- `ICACHE_STATS_EN` defined: `hit_count` and `miss_count` ports and registers exist.
  - `hit_count` increments on every cycle with a hit.
  - `miss_count` increments once per IDLE→REQ transition.
  - Both are 32-bit, wrap modulo 2^32, and are not cleared by `flush`.
- `ICACHE_STATS_EN` undefined: ports and registers are absent; behaviour is otherwise identical.

## Structure
- `icache_pkg`:
  - state enum `icache_state_t` {IDLE, REQ, FILL};
  - NOP constant 32'h0000_0013;
  - width helper functions for `OFF_W`/`IDX_W`/`TAG_W`.
- Sub-module `icache_refill_ctrl`: the REQ/FILL FSM, beat counter, latched address, and poison flag. It produces array write enables, write index/word, and the tag write.
- The top level holds the valid/tag/data arrays, hit logic, and stats counters.

## Test plan
- Reset, then `fetch_valid`, PC=0x0 → `instr_valid`=0 and `mem_req_valid`=1, `mem_req_addr`=0x0 next cycle. Return beats 0x00500093, 0x00208113, 0x0, 0x0 → on cycle 6 `instr_valid`=1 and `instruction`=0x00500093. PC=0x4 gives 0x00208113 with zero latency.
- Conflict: fill PC=0x0, then PC=0x400 (same index for defaults) → miss, refill replaces the line. PC=0x0 then misses again.
- Backpressure: `mem_req_ready` low for 5 cycles → `mem_req_valid` and `mem_req_addr` stable throughout. Gaps between beats stretch FILL, and data still lands in word order.
- Flush during FILL at beat 2 → refill completes, line not valid, same PC misses again. Flush in IDLE after a fill → next fetch misses.
- `RESET_N` low during FILL → state IDLE, `mem_req_valid`=0. A stray `mem_resp_valid` after release writes nothing.
- With `ICACHE_STATS_EN`: 2 misses plus 10 hit cycles → `miss_count`=2, `hit_count`=10.
